ram_port_arbiter: RTL

Sequencing controller that shares the single-port data `ram` (word-addressed, posedge write, negedge read) between two requesters: port 0 is the core load/store unit, port 1 is the loader/DMA path. It arbitrates round-robin, runs each access as a fixed-length sequence on the RAM port, and emulates byte and halfword stores with a read-modify-write, because the RAM has no byte enables. It sits between the requesters and one `ram` instance; nothing else drives that RAM.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/ram_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the RAM port arbiter: FSM states, port/strobe widths
// and the byte-lane merge used by read-modify-write stores.
package mem_ctrl_pkg;

  localparam int NUM_PORTS = 2;
  localparam int STRB_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0]       old_w,
    input logic [31:0]       new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [31:0] r;
    for (int i = 0; i < STRB_W; i++) begin
      r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Ports: clk, rst (sync, active high),
// req[1:0] in, advance in (commit the current grant), grant[1:0] out (one-hot).
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two requesters; partial stores use RMW.
// Ports: clk, rst; req_valid/ready/we/addr/wdata/wstrb per port; rsp_valid, rsp_rdata; ram_re/we/addr/wd/rd.
module ram_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS-1:0][29:0]       req_addr,
  input  logic [NUM_PORTS-1:0][31:0]       req_wdata,
  input  logic [NUM_PORTS-1:0][STRB_W-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [31:0]                      rsp_rdata,
  output logic                             ram_re,
  output logic                             ram_we,
  output logic [29:0]                      ram_addr,
  output logic [31:0]                      ram_wd,
  input  logic [31:0]                      ram_rd
);

  state_t state, state_n;

  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] rsp_n;
  logic                 hs;
  logic                 g;
  logic                 owner;
  logic [31:0]          wdata_q;
  logic [STRB_W-1:0]    wstrb_q;

  logic              sel_we;
  logic [29:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [STRB_W-1:0] sel_strb;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (hs),
    .grant   (grant)
  );

  assign g         = grant[1];
  assign sel_we    = req_we[g];
  assign sel_addr  = req_addr[g];
  assign sel_wdata = req_wdata[g];
  assign sel_strb  = req_wstrb[g];

  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_n     = '0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    hs        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rst && grant != '0) begin
          hs        = 1'b1;
          req_ready = grant;
          if (!sel_we) begin
            state_n = S_READ;
          end else if (sel_strb == 4'hF) begin
            state_n = S_WRITE;
          end else if (sel_strb == 4'h0) begin
            // nothing to store: acknowledge without touching the RAM
            rsp_n = grant;
          end else begin
            state_n = S_RMW_RD;
          end
        end
      end
      S_READ: begin
        ram_re  = 1'b1;
        state_n = S_IDLE;
        rsp_n   = owner ? 2'b10 : 2'b01;
      end
      S_WRITE: begin
        ram_we  = 1'b1;
        state_n = S_IDLE;
        rsp_n   = owner ? 2'b10 : 2'b01;
      end
      S_RMW_RD: begin
        ram_re  = 1'b1;
        state_n = S_RMW_WR;
      end
      S_RMW_WR: begin
        ram_we  = 1'b1;
        state_n = S_IDLE;
        rsp_n   = owner ? 2'b10 : 2'b01;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_wd    <= '0;
      owner     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= rsp_n;
      if (hs) begin
        owner   <= g;
        wdata_q <= sel_wdata;
        wstrb_q <= sel_strb;
        // ram_addr/ram_wd double as the access latches; keep them
        // untouched when no RAM access follows.
        if (!sel_we || sel_strb != 4'h0) begin
          ram_addr <= sel_addr;
        end
        if (sel_we && sel_strb == 4'hF) begin
          ram_wd <= sel_wdata;
        end
      end
      if (state == S_READ) begin
        rsp_rdata <= ram_rd;
      end
      if (state == S_RMW_RD) begin
        ram_wd <= merge_bytes(ram_rd, wdata_q, wstrb_q);
      end
    end
  end

endmodule
